mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port arbiter/sequencer that shares the single-port 1024x16 `memory` between the CPU instruction-fetch path (read-only) and the CPU data path (load/store).
- Sits between the CPU and `memory`. Drives MemRead/MemWrite/ADDR/Data_in and consumes `memory` Data_out, which has 1-cycle registered read latency.
- Round-robin grant, in-order pipelined issue (one access per cycle), out-of-range address trapping, saturating per-port grant counters.

Parameters:
- MEM_WORDS, 1024, number of implemented memory words; addresses >= MEM_WORDS are trapped.
- AW, 16, address width.
- DW, 16, data width.
- CNT_W, 16, width of each grant counter.

Ports:
- CLK  in  1  clock. Single clock domain.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  AW  fetch word address.
- if_ack  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DW  fetch read data.
- if_err  out  1  fetch address out of range.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data word address.
- d_wdata  in  DW  store data.
- d_ack  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid.
- d_rdata  out  DW  load data.
- d_err  out  1  data address out of range.
- cnt_clr  in  1  synchronous clear of grant counters.
- if_gnt_cnt  out  CNT_W  saturating count of fetch grants.
- d_gnt_cnt  out  CNT_W  saturating count of data grants.
- MemRead  out  1  to memory.
- MemWrite  out  1  to memory.
- ADDR  out  AW  to memory.
- Data_in  out  DW  to memory.
- MemData  in  DW  from memory Data_out.

Behaviour:
- Reset (synchronous, active-high) values: MemRead = MemWrite = 0; ADDR = Data_in = 0; all ack/rvalid/err = 0; rdata = 0; counters = 0; rr pointer = FETCH; both in-flight tag stages invalid.
- While reset is high, no ack is asserted and no memory strobe is driven. Memory preload during reset is never disturbed.
- Arbitration is combinational within cycle t:
  - Only one requester active: it is granted.
  - Both active: the port not granted last is granted. The pointer updates only on a grant.
  - ack is asserted combinationally in t for the granted port only. The requester samples ack at the posedge ending t.
- Issue, registered at the end of t and visible in t+1:
  - In range, load/fetch: MemRead = 1, ADDR = addr.
  - In range, store: MemWrite = 1, ADDR = addr, Data_in = wdata.
  - Out of range: no strobe.
  - Strobes are low in any cycle with no issue.
- Tag pipeline: two stages {valid, port, is_read, err}, advancing every cycle.
  - Stage 2 is valid in t+2.
  - Read: port rvalid = 1 in t+2, rdata = MemData, or 0 when err.
  - err: port err = 1 in t+2 for both reads and trapped writes. A trapped write produces no rvalid.
  - rdata holds its last value when rvalid = 0.
- Latency and throughput:
  - Read: ack at t, rvalid at t+2.
  - Store: memory updated at the posedge ending t+1.
  - One grant per cycle, back-to-back sustained.
  - Strictly in-order, so a load issued the cycle after a store to the same address returns the new data.
- No buffering. An ungranted requester waits, holding req and its payload stable. A dropped req before ack is legal and is simply not serviced.
- Counters:
  - Increment on the owning port's ack and saturate at all-ones.
  - cnt_clr has priority over increment in the same cycle.
- Reset mid-operation: in-flight tags are discarded; no rvalid/err appears in the cycles following reset deassert.
- Width rule: range check is addr < MEM_WORDS on the full AW bits. ADDR passes through unchanged.

Decomposition:
- Package mem_arb_pkg:
  - Port IDs PORT_IF = 0, PORT_D = 1.
  - Tag struct {valid, port, is_read, err}.
  - Default MEM_WORDS/AW/DW constants.
- Sub-module rr_arb2: two-request round-robin arbiter with pointer register. Inputs CLK, reset, req[1:0]; outputs gnt[1:0].
- Everything else (issue registers, tag pipeline, counters) lives in mem_arbiter.

Test Plan:
1. Reset then fetch: if_req, if_addr = 0 held → if_ack in cycle 0, MemRead = 1/ADDR = 0 in cycle 1, if_rvalid with if_rdata = 16'b0010011111100111 in cycle 2.
2. Contention: both req every cycle (fetch 1..4, data loads 10..13) → grants alternate IF, D, IF, D…; each port gets exactly 4 acks in 8 cycles; rvalid order matches ack order.
3. Store→load forwarding-by-order: d store addr 30 data 16'd69, next cycle d load addr 30 → d_rvalid two cycles after second ack with d_rdata = 69.
4. Out of range: d load addr 1024 → d_ack, no MemRead, d_err = 1 and d_rvalid = 1 with d_rdata = 0 at t+2. Fetch addr 16'hFFFF → if_err = 1.
5. Reset mid-flight: fetch acked at t, reset asserted at t+1 → no if_rvalid at t+2, all outputs at reset values, counters 0.
6. Counters: 65540 data grants with CNT_W = 16 → d_gnt_cnt saturates at 16'hFFFF. cnt_clr together with an ack → 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int MEM_WORDS_DEF = 1024;
  localparam int AW_DEF        = 16;
  localparam int DW_DEF        = 16;
  localparam int CNT_W_DEF     = 16;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_e;

  // One in-flight access, carried alongside the memory's read latency.
  typedef struct packed {
    logic  valid;
    port_e port;
    logic  is_read;
    logic  err;
  } tag_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU-side request ports, memory-side strobes and grant counters of mem_arbiter.
interface mem_arbiter_if #(
  parameter int AW    = mem_arb_pkg::AW_DEF,
  parameter int DW    = mem_arb_pkg::DW_DEF,
  parameter int CNT_W = mem_arb_pkg::CNT_W_DEF
);
  import mem_arb_pkg::*;

  // Handshake: a requester raises req with a stable payload and holds both
  // until it samples ack high at a rising edge; ack is combinational in that
  // cycle. Dropping req before ack withdraws the request without side effects.
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          if_err;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          d_err;

  logic             cnt_clr;
  logic [CNT_W-1:0] if_gnt_cnt;
  logic [CNT_W-1:0] d_gnt_cnt;

  logic          MemRead;
  logic          MemWrite;
  logic [AW-1:0] ADDR;
  logic [DW-1:0] Data_in;
  logic [DW-1:0] MemData;

  port_e rr_ptr;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, cnt_clr, MemData,
    output if_ack, if_rvalid, if_rdata, if_err,
    output d_ack, d_rvalid, d_rdata, d_err,
    output if_gnt_cnt, d_gnt_cnt,
    output MemRead, MemWrite, ADDR, Data_in, rr_ptr
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, cnt_clr, MemData,
    input  if_ack, if_rvalid, if_rdata, if_err,
    input  d_ack, d_rvalid, d_rdata, d_err,
    input  if_gnt_cnt, d_gnt_cnt,
    input  MemRead, MemWrite, ADDR, Data_in, rr_ptr
  );

endinterface

// File: rtl/mem_arbiter_rr.sv
// Two-request round-robin arbiter; ptr names the port that wins the next tie.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       CLK,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output port_e      ptr
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (ptr == PORT_IF) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      ptr <= PORT_IF;
    end else if (gnt[0]) begin
      ptr <= PORT_D;
    end else if (gnt[1]) begin
      ptr <= PORT_IF;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data load/store,
// issuing one in-order access per cycle and returning read data two cycles later.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic          CLK,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  logic [1:0]       req;
  logic [1:0]       gnt;
  logic             issue;
  logic             is_read;
  logic             trap;
  port_e            gnt_port;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    rd_word;
  tag_t             tag1, tag2;
  logic             mem_read_q, mem_write_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic [DW-1:0]    if_rdata_q, d_rdata_q;
  logic [CNT_W-1:0] if_cnt, d_cnt;

  // Requests are masked during reset so the pointer and counters stay put.
  assign req = {bus.d_req, bus.if_req} & {2{~reset}};

  rr_arb2 u_rr (
    .CLK   (CLK),
    .reset (reset),
    .req   (req),
    .gnt   (gnt),
    .ptr   (bus.rr_ptr)
  );

  always_comb begin
    issue    = |gnt;
    gnt_port = gnt[1] ? PORT_D : PORT_IF;
    sel_addr = gnt[1] ? bus.d_addr : bus.if_addr;
    is_read  = ~gnt[1] | ~bus.d_we;
    trap     = ({1'b0, sel_addr} >= (AW+1)'(MEM_WORDS));
    rd_word  = tag2.err ? '0 : bus.MemData;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      tag1        <= '0;
      tag2        <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_cnt      <= '0;
      d_cnt       <= '0;
    end else begin
      mem_read_q  <= issue & is_read & ~trap;
      mem_write_q <= issue & ~is_read & ~trap;
      if (issue && !trap) addr_q <= sel_addr;
      if (issue && !is_read && !trap) wdata_q <= bus.d_wdata;
      tag1 <= '{valid: issue, port: gnt_port, is_read: is_read, err: trap};
      tag2 <= tag1;
      if (bus.if_rvalid) if_rdata_q <= bus.if_rdata;
      if (bus.d_rvalid)  d_rdata_q  <= bus.d_rdata;
      if (bus.cnt_clr) begin
        if_cnt <= '0;
        d_cnt  <= '0;
      end else begin
        if (gnt[0] && !(&if_cnt)) if_cnt <= if_cnt + CNT_W'(1);
        if (gnt[1] && !(&d_cnt))  d_cnt  <= d_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.if_ack = gnt[0];
  assign bus.d_ack  = gnt[1];

  // Strobes are also gated by reset so a preload under reset is never touched.
  assign bus.MemRead  = mem_read_q & ~reset;
  assign bus.MemWrite = mem_write_q & ~reset;
  assign bus.ADDR     = addr_q;
  assign bus.Data_in  = wdata_q;

  assign bus.if_rvalid = ~reset & tag2.valid & (tag2.port == PORT_IF) & tag2.is_read;
  assign bus.if_err    = ~reset & tag2.valid & (tag2.port == PORT_IF) & tag2.err;
  assign bus.d_rvalid  = ~reset & tag2.valid & (tag2.port == PORT_D) & tag2.is_read;
  assign bus.d_err     = ~reset & tag2.valid & (tag2.port == PORT_D) & tag2.err;

  assign bus.if_rdata = reset ? '0 : (bus.if_rvalid ? rd_word : if_rdata_q);
  assign bus.d_rdata  = reset ? '0 : (bus.d_rvalid  ? rd_word : d_rdata_q);

  assign bus.if_gnt_cnt = if_cnt;
  assign bus.d_gnt_cnt  = d_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// against an in-order transaction model with its own memory image.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int MW = 1024;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam logic [DW-1:0] WORD0 = 16'b0010011111100111;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;

  mem_arbiter_if #(.AW(AW), .DW(DW), .CNT_W(CW)) bus ();

  mem_arbiter #(.MEM_WORDS(MW), .AW(AW), .DW(DW), .CNT_W(CW)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  // Memory with one-cycle registered read.
  logic [DW-1:0] mem [MW];
  logic [DW-1:0] mem_q = '0;
  always @(posedge CLK) begin
    if (bus.MemWrite) mem[bus.ADDR[9:0]] <= bus.Data_in;
    if (bus.MemRead)  mem_q <= mem[bus.ADDR[9:0]];
  end
  assign bus.MemData = mem_q;

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } strobe_t;

  typedef struct packed {
    logic          if_rv;
    logic          if_er;
    logic          d_rv;
    logic          d_er;
    logic [DW-1:0] data;
  } resp_t;

  strobe_t       strobe_q[$];
  resp_t         resp_q[$];
  logic [DW-1:0] ref_mem [MW];
  logic          m_prio;
  logic [CW-1:0] m_if_cnt, m_d_cnt;
  logic [DW-1:0] m_if_hold, m_d_hold;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic          s_if_ack, s_d_ack, s_mem_read, s_if_rvalid, s_if_err, s_d_rvalid, s_d_err;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_if_rdata, s_d_rdata;
  logic [CW-1:0] s_if_cnt, s_d_cnt;

  int       fi, di;
  logic [7:0] seq;
  logic     if_pend, d_pend;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic model_check();
    strobe_t       s, ns;
    resp_t         r, nr;
    logic          gv, g, rd, er;
    logic [AW-1:0] a;
    logic [DW-1:0] e_if, e_d;
    if (reset) begin
      chk("rst_if_ack", 32'(bus.if_ack), 0);
      chk("rst_d_ack", 32'(bus.d_ack), 0);
      chk("rst_memread", 32'(bus.MemRead), 0);
      chk("rst_memwrite", 32'(bus.MemWrite), 0);
      chk("rst_if_rvalid", 32'(bus.if_rvalid), 0);
      chk("rst_d_rvalid", 32'(bus.d_rvalid), 0);
      chk("rst_if_err", 32'(bus.if_err), 0);
      chk("rst_d_err", 32'(bus.d_err), 0);
      chk("rst_if_rdata", 32'(bus.if_rdata), 0);
      chk("rst_d_rdata", 32'(bus.d_rdata), 0);
      m_prio = 1'b0;
      m_if_cnt = '0; m_d_cnt = '0;
      m_if_hold = '0; m_d_hold = '0;
      strobe_q.delete(); resp_q.delete();
      strobe_q.push_back('0);
      resp_q.push_back('0); resp_q.push_back('0);
    end else begin
      gv = bus.if_req | bus.d_req;
      g  = (bus.if_req && bus.d_req) ? m_prio : bus.d_req;
      chk("if_ack", 32'(bus.if_ack), 32'(gv & !g));
      chk("d_ack", 32'(bus.d_ack), 32'(gv & g));
      chk("if_gnt_cnt", 32'(bus.if_gnt_cnt), 32'(m_if_cnt));
      chk("d_gnt_cnt", 32'(bus.d_gnt_cnt), 32'(m_d_cnt));

      s = strobe_q.pop_front();
      chk("memread", 32'(bus.MemRead), 32'(s.rd));
      chk("memwrite", 32'(bus.MemWrite), 32'(s.wr));
      if (s.rd || s.wr) chk("mem_addr", 32'(bus.ADDR), 32'(s.addr));
      if (s.wr) begin
        chk("mem_wdata", 32'(bus.Data_in), 32'(s.wdata));
        ref_mem[s.addr[9:0]] = s.wdata;
      end

      r = resp_q.pop_front();
      e_if = r.if_rv ? r.data : m_if_hold;
      e_d  = r.d_rv  ? r.data : m_d_hold;
      chk("if_rvalid", 32'(bus.if_rvalid), 32'(r.if_rv));
      chk("if_err", 32'(bus.if_err), 32'(r.if_er));
      chk("if_rdata", 32'(bus.if_rdata), 32'(e_if));
      chk("d_rvalid", 32'(bus.d_rvalid), 32'(r.d_rv));
      chk("d_err", 32'(bus.d_err), 32'(r.d_er));
      chk("d_rdata", 32'(bus.d_rdata), 32'(e_d));
      m_if_hold = e_if;
      m_d_hold  = e_d;

      ns = '0;
      nr = '0;
      if (gv) begin
        a  = g ? bus.d_addr : bus.if_addr;
        rd = !g || !bus.d_we;
        er = (a >= 16'(MW));
        ns.rd = rd & !er;
        ns.wr = !rd & !er;
        ns.addr = a;
        ns.wdata = bus.d_wdata;
        if (rd && !er) nr.data = ref_mem[a[9:0]];
        nr.if_rv = !g;
        nr.if_er = !g & er;
        nr.d_rv  = g & rd;
        nr.d_er  = g & er;
        m_prio = !g;
      end
      strobe_q.push_back(ns);
      resp_q.push_back(nr);

      if (bus.cnt_clr) begin
        m_if_cnt = '0;
        m_d_cnt  = '0;
      end else if (gv) begin
        if (!g && m_if_cnt != '1) m_if_cnt = m_if_cnt + 1'b1;
        if (g && m_d_cnt != '1)   m_d_cnt  = m_d_cnt + 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    s_if_ack = bus.if_ack;     s_d_ack = bus.d_ack;
    s_mem_read = bus.MemRead;  s_addr = bus.ADDR;
    s_if_rvalid = bus.if_rvalid; s_if_err = bus.if_err; s_if_rdata = bus.if_rdata;
    s_d_rvalid = bus.d_rvalid; s_d_err = bus.d_err; s_d_rdata = bus.d_rdata;
    s_if_cnt = bus.if_gnt_cnt; s_d_cnt = bus.d_gnt_cnt;
    model_check();
    cyc++;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.cnt_clr = 1'b0;
    for (int i = 0; i < MW; i++) mem[i] = 16'(i * 40503 + 3);
    mem[0] = WORD0;
    for (int i = 0; i < MW; i++) ref_mem[i] = mem[i];
    @(posedge CLK);
    #1;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Single fetch straight out of reset.
    bus.if_req = 1'b1; bus.if_addr = 16'd0;
    tick();
    chk("t1_if_ack", 32'(s_if_ack), 1);
    bus.if_req = 1'b0;
    tick();
    chk("t1_memread", 32'(s_mem_read), 1);
    chk("t1_addr", 32'(s_addr), 0);
    tick();
    chk("t1_if_rvalid", 32'(s_if_rvalid), 1);
    chk("t1_if_rdata", 32'(s_if_rdata), 32'(WORD0));
    idle(2);

    // Contention from a fresh pointer: strict IF/D alternation.
    reset = 1'b1; tick(); reset = 1'b0;
    fi = 0; di = 0; seq = '0;
    for (int i = 0; i < 8; i++) begin
      bus.if_req = (fi < 4); bus.if_addr = 16'(1 + fi);
      bus.d_req = (di < 4); bus.d_we = 1'b0; bus.d_addr = 16'(10 + di);
      tick();
      seq[i] = s_d_ack;
      if (s_if_ack) fi++;
      if (s_d_ack) di++;
    end
    chk("t2_if_acks", 32'(fi), 4);
    chk("t2_d_acks", 32'(di), 4);
    chk("t2_order", 32'(seq), 32'h000000AA);
    idle(3);

    // Store then load of the same word on consecutive cycles.
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'd30; bus.d_wdata = 16'd69;
    tick();
    chk("t3_store_ack", 32'(s_d_ack), 1);
    bus.d_we = 1'b0;
    tick();
    chk("t3_load_ack", 32'(s_d_ack), 1);
    bus.d_req = 1'b0;
    tick();
    tick();
    chk("t3_d_rvalid", 32'(s_d_rvalid), 1);
    chk("t3_d_rdata", 32'(s_d_rdata), 69);

    // Out-of-range addresses on both ports.
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'd1024;
    tick();
    chk("t4_d_ack", 32'(s_d_ack), 1);
    bus.d_req = 1'b0;
    tick();
    chk("t4_no_memread", 32'(s_mem_read), 0);
    tick();
    chk("t4_d_err", 32'(s_d_err), 1);
    chk("t4_d_rvalid", 32'(s_d_rvalid), 1);
    chk("t4_d_rdata", 32'(s_d_rdata), 0);
    bus.if_req = 1'b1; bus.if_addr = 16'hFFFF;
    tick();
    bus.if_req = 1'b0;
    tick();
    tick();
    chk("t4_if_err", 32'(s_if_err), 1);
    idle(2);

    // Reset lands while a fetch is in flight.
    bus.if_req = 1'b1; bus.if_addr = 16'd5;
    tick();
    chk("t5_if_ack", 32'(s_if_ack), 1);
    reset = 1'b1; bus.if_req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("t5_no_rvalid", 32'(s_if_rvalid), 0);
    chk("t5_no_err", 32'(s_if_err), 0);
    chk("t5_if_cnt", 32'(s_if_cnt), 0);
    chk("t5_d_cnt", 32'(s_d_cnt), 0);

    // Saturation of the data grant counter, then clear racing an ack.
    bus.d_req = 1'b1; bus.d_we = 1'b0;
    for (int i = 0; i < 65540; i++) begin
      bus.d_addr = 16'($urandom_range(0, MW - 1));
      tick();
    end
    bus.d_req = 1'b0;
    tick();
    chk("t6_d_cnt_sat", 32'(s_d_cnt), 32'h0000FFFF);
    bus.d_req = 1'b1; bus.d_addr = 16'd3; bus.cnt_clr = 1'b1;
    tick();
    bus.cnt_clr = 1'b0; bus.d_req = 1'b0;
    tick();
    chk("t6_d_cnt_clr", 32'(s_d_cnt), 0);
    idle(2);

    // Random traffic: mixed loads/stores/fetches, drops, clears and resets.
    if_pend = 1'b0; d_pend = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!if_pend && $urandom_range(0, 2) == 0) begin
        if_pend = 1'b1;
        bus.if_addr = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
      end else if (if_pend && $urandom_range(0, 40) == 0) begin
        if_pend = 1'b0;
      end
      if (!d_pend && $urandom_range(0, 1) == 0) begin
        d_pend = 1'b1;
        bus.d_we = 1'($urandom_range(0, 1));
        bus.d_wdata = 16'($urandom);
        bus.d_addr = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
      end else if (d_pend && $urandom_range(0, 40) == 0) begin
        d_pend = 1'b0;
      end
      bus.cnt_clr = ($urandom_range(0, 99) == 0);
      reset = ($urandom_range(0, 299) == 0);
      bus.if_req = if_pend;
      bus.d_req = d_pend;
      tick();
      if (s_if_ack || reset) if_pend = 1'b0;
      if (s_d_ack || reset) d_pend = 1'b0;
    end
    reset = 1'b0;
    bus.cnt_clr = 1'b0;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
